// File: rtl/uart_line_rx.sv
// uart_line_rx
//   Receives 8N1-style UART frames, assembles characters into a line buffer
//   and flags a complete line when the terminator character arrives. The
//   buffer is read one character at a time through rd_en / rd_data.
//
//   Optional feature: define UART_LINE_RX_PARITY_EN to expect one even-parity
//   bit after the data bits. Without it, parity_err is tied low.
//
//   Ports:
//     clk        sole clock, rising edge
//     rst_n      synchronous active-low reset
//     rx         asynchronous serial input, idle high
//     rd_en      pop one character from the line buffer
//     ovf_clr    clear the sticky overflow flag
//     rd_data    popped character (valid with rd_valid)
//     rd_valid   one-cycle pulse, rd_data valid
//     line_ready complete line held in the buffer
//     line_len   character count of the held line
//     empty      line buffer holds no characters
//     overflow   sticky, a character was dropped
//     frame_err  one-cycle pulse, bad stop bit
//     parity_err one-cycle pulse, bad parity
module uart_line_rx #(
  parameter int         CLK_HZ    = 100000000,
  parameter int         BAUD      = 115200,
  parameter int         DATA_BITS = 8,
  parameter int         DEPTH     = 16,
  parameter logic [7:0] TERM      = 8'h72,
  localparam int        LW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 rd_en,
  input  logic                 ovf_clr,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 line_ready,
  output logic [LW-1:0]        line_len,
  output logic                 empty,
  output logic                 overflow,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int PW   = $clog2(DEPTH);
  localparam logic [7:0]           TERM8  = TERM;
  localparam logic [DATA_BITS-1:0] TERM_C = TERM8[DATA_BITS-1:0];

`ifdef UART_LINE_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // ---------------------------------------------------------------------
  // Input synchronizer and line-idle qualification
  // ---------------------------------------------------------------------
  logic [1:0] sync_reg;
  logic [1:0] flush_reg;    // marks when sync_reg holds real samples again
  logic       rx_s;
  logic       rx_prev_reg;
  logic       armed_reg;    // rx seen high since reset

  assign rx_s = sync_reg[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg    <= 2'b11;
      flush_reg   <= 2'b00;
      rx_prev_reg <= 1'b1;
      armed_reg   <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], rx};
      flush_reg   <= {flush_reg[0], 1'b1};
      rx_prev_reg <= rx_s;
      // The reset value of the synchronizer is not a real observation of
      // the line, so only arm once the flops have been refilled from rx.
      if (rx_s && flush_reg[1]) begin
        armed_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------
  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [2:0]             bit_reg, bit_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   ferr_wait_reg, ferr_wait_next;
  logic                   acc;        // character accepted this cycle
  logic                   ferr_evt;
`ifdef UART_LINE_RX_PARITY_EN
  logic                   par_bad_reg, par_bad_next;
  logic                   perr_evt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      ferr_wait_reg <= 1'b0;
`ifdef UART_LINE_RX_PARITY_EN
      par_bad_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      ferr_wait_reg <= ferr_wait_next;
`ifdef UART_LINE_RX_PARITY_EN
      par_bad_reg   <= par_bad_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_next       = bit_reg;
    shift_next     = shift_reg;
    ferr_wait_next = ferr_wait_reg;
    acc            = 1'b0;
    ferr_evt       = 1'b0;
`ifdef UART_LINE_RX_PARITY_EN
    par_bad_next   = par_bad_reg;
    perr_evt       = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (armed_reg && rx_prev_reg && !rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        // Re-check the start bit near its middle; a high line means glitch.
        if (cnt_reg == CW'(HALF - 1)) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next = DATA;
            bit_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (cnt_reg == CW'(CPB - 1)) begin
          cnt_next   = '0;
          // LSB arrives first: shift in from the top.
          shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
          if (bit_reg == 3'(DATA_BITS - 1)) begin
`ifdef UART_LINE_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
`ifdef UART_LINE_RX_PARITY_EN
      PARITY: begin
        if (cnt_reg == CW'(CPB - 1)) begin
          cnt_next     = '0;
          par_bad_next = (^shift_reg) ^ rx_s;   // even parity over data+bit
          perr_evt     = (^shift_reg) ^ rx_s;
          state_next   = STOP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
`endif
      STOP: begin
        if (ferr_wait_reg) begin
          // After a bad stop bit, hold off until the line returns high so
          // the low level is not mistaken for a new start bit.
          if (rx_s) begin
            ferr_wait_next = 1'b0;
            state_next     = IDLE;
          end
        end else if (cnt_reg == CW'(CPB - 1)) begin
          cnt_next = '0;
          if (rx_s) begin
            state_next = IDLE;
`ifdef UART_LINE_RX_PARITY_EN
            acc        = !par_bad_reg;
`else
            acc        = 1'b1;
`endif
          end else begin
            ferr_evt       = 1'b1;
            ferr_wait_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Line buffer
  // ---------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]        count_reg, count_next;
  logic [DATA_BITS-1:0] rd_data_reg;
  logic                 rd_valid_reg, line_ready_reg, overflow_reg;
  logic                 frame_err_reg;
  logic [LW-1:0]        line_len_reg;
  logic [DATA_BITS-1:0] term_bit;
  logic                 term_hit, wr, rd, drop, line_set;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_BITS; gi++) begin : g_term
      assign term_bit[gi] = ~(shift_reg[gi] ^ TERM_C[gi]);
    end
  endgenerate

  assign term_hit = &term_bit;

  always_comb begin
    rd   = rd_en && (count_reg != '0);
    wr   = acc && !term_hit && !line_ready_reg && (count_reg < LW'(DEPTH));
    drop = acc && !term_hit && !wr;
    count_next = count_reg;
    if (wr && !rd) begin
      count_next = count_reg + LW'(1);
    end else if (!wr && rd) begin
      count_next = count_reg - LW'(1);
    end
    // A terminator closes the line only if it would not be empty.
    line_set = acc && term_hit && !line_ready_reg && (count_next != '0);
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr_reg] <= shift_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      rd_data_reg    <= '0;
      rd_valid_reg   <= 1'b0;
      line_ready_reg <= 1'b0;
      line_len_reg   <= '0;
      overflow_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      rd_valid_reg  <= rd;
      frame_err_reg <= ferr_evt;
      count_reg     <= count_next;
      if (rd) begin
        rd_data_reg <= mem[rd_ptr_reg];
        rd_ptr_reg  <= rd_ptr_reg + PW'(1);
      end
      if (wr) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (line_set) begin
        line_ready_reg <= 1'b1;
        line_len_reg   <= count_next;
      end else if (rd && (count_next == '0)) begin
        line_ready_reg <= 1'b0;
      end
      // A drop in the same cycle as a clear request keeps the flag set.
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (ovf_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

`ifdef UART_LINE_RX_PARITY_EN
  logic parity_err_reg;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_err_reg <= 1'b0;
    end else begin
      parity_err_reg <= perr_evt;
    end
  end
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

  assign rd_data    = rd_data_reg;
  assign rd_valid   = rd_valid_reg;
  assign line_ready = line_ready_reg;
  assign line_len   = line_len_reg;
  assign empty      = (count_reg == '0);
  assign overflow   = overflow_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: doc/uart_line_rx.md
UART_LINE_RX -- requirements
Module: uart_line_rx

Interface
REQ-001 Parameter CLK_HZ, default 100000000, meaning system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, meaning line bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, SHALL be >= 4).
REQ-003 Parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..8.
REQ-004 Parameter DEPTH, default 16, meaning line buffer capacity in characters, power of two, >= 2.
REQ-005 Parameter TERM, default 8'h72, meaning the line terminator character; only its low DATA_BITS bits are compared.
REQ-006 Port list (LW = $clog2(DEPTH+1)):
  clk  in  1  sole clock, rising edge.
  rst_n  in  1  synchronous active-low reset.
  rx  in  1  asynchronous serial input, idle high.
  rd_en  in  1  pop one character from the line buffer.
  ovf_clr  in  1  clear the sticky overflow flag.
  rd_data  out  DATA_BITS  popped character.
  rd_valid  out  1  rd_data valid, one-cycle pulse.
  line_ready  out  1  complete line held in the buffer.
  line_len  out  LW  character count of the held line.
  empty  out  1  line buffer holds no characters.
  overflow  out  1  sticky, a character was dropped.
  frame_err  out  1  one-cycle pulse, bad stop bit.
  parity_err  out  1  one-cycle pulse, bad parity (tied 0 without the macro).

Function
REQ-007 rx SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-008 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-009 IDLE -> START on a synchronized falling edge, once rx has been seen high for at least 1 cycle since reset.
REQ-010 START: after CLKS_PER_BIT/2 cycles, rx low -> DATA; rx high -> IDLE (glitch, no flag).
REQ-011 DATA: samples DATA_BITS bits LSB first, each CLKS_PER_BIT cycles after the previous sample; then -> PARITY (macro defined) or STOP.
REQ-012 STOP: samples rx after CLKS_PER_BIT cycles. High -> character accepted. Low -> frame_err pulses 1 cycle, character discarded, state returns to IDLE only after rx is seen high.
REQ-013 Accepted character equal to TERM, buffer non-empty, line_ready low: TERM not stored; line_ready set next cycle; line_len latched with the stored count.
REQ-014 Accepted TERM with the buffer empty SHALL be ignored (no empty lines).
REQ-015 Accepted non-TERM character SHALL be written if line_ready is low and count < DEPTH; otherwise it is dropped and overflow set.
REQ-016 rd_en with empty low SHALL pop the oldest character: rd_data and rd_valid appear the following cycle. rd_en with empty high SHALL be ignored and rd_valid stays low.
REQ-017 A write and a pop in the same cycle SHALL both occur; count unchanged.
REQ-018 line_ready SHALL clear in the cycle after the pop that empties the buffer.
REQ-019 Buffer pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH.
REQ-020 ovf_clr SHALL clear overflow. If ovf_clr and a drop coincide in the same cycle, the set wins.

Reset
REQ-021 While rst_n is low at a clk edge: FSM = IDLE, counters and pointers = 0, synchronizer flops = 1.
REQ-022 Output reset values: rd_data = 0, rd_valid = 0, line_ready = 0, line_len = 0, empty = 1, overflow = 0, frame_err = 0, parity_err = 0.
REQ-023 Reset mid-frame SHALL abandon the frame. Reception resumes only after rx is seen high (REQ-009).

Configuration
REQ-024 Macro UART_LINE_RX_PARITY_EN defined: each frame carries one even-parity bit after the data bits, sampled in PARITY.
REQ-025 With the macro, a parity mismatch pulses parity_err 1 cycle and the character is discarded; the stop bit is still checked.
REQ-026 Macro undefined: no PARITY state, frame = start + DATA_BITS + stop, parity_err tied 0.

Verification
All scenarios use CLK_HZ = 1152000 and BAUD = 115200, giving 10 clocks per bit.
REQ-027 Send "hi" then 8'h72; read until empty -> line_ready = 1, line_len = 2; rd_data sequence 8'h68, 8'h69; line_ready = 0 after the last pop.
REQ-028 Start pulse held low for 3 clocks, then high -> no write, no flags, FSM back in IDLE.
REQ-029 Send 8'h41 with the stop bit held low -> frame_err pulses once; empty stays 1; the next valid frame is received normally.
REQ-030 DEPTH = 4, send 5 non-TERM characters -> first 4 stored, overflow = 1; ovf_clr -> overflow = 0.
REQ-031 Assert rst_n low during a DATA bit of 8'h55, release with rx still low -> no character stored until rx goes high and a full new frame arrives.
REQ-032 With UART_LINE_RX_PARITY_EN, send 8'h03 with parity bit 1 -> parity_err pulses, nothing stored; the same byte with parity bit 0 is stored.
